// File: rtl/enff_write_arbiter_if.sv
// enff_write_arbiter_if
// Bundles the requester side and the flip-flop bank side of the write arbiter.
//   REQ  [NREQ]        per-requester write request (level)
//   DIN  [NREQ*WIDTH]  per-requester write data, DIN[i*WIDTH +: WIDTH] = requester i
//   GNT  [NREQ]        one-hot grant, zero when idle
//   D    [WIDTH]       registered data to the bank's D inputs
//   EN                 one-cycle write enable to the bank's En inputs
//   BUSY               high whenever the arbiter is not idle
// master: requesters/bank side (drives REQ/DIN); slave: the arbiter.
interface enff_write_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       REQ;
  logic [NREQ*WIDTH-1:0] DIN;
  logic [NREQ-1:0]       GNT;
  logic [WIDTH-1:0]      D;
  logic                  EN;
  logic                  BUSY;

  modport master (output REQ, DIN, input GNT, D, EN, BUSY);
  modport slave  (input REQ, DIN, output GNT, D, EN, BUSY);
endinterface

// File: rtl/enff_write_arbiter.sv
// enff_write_arbiter
// Shares one bank of enable flip-flops between NREQ requesters. In IDLE the winning requester's
// data is captured into D and EN pulses for one cycle (WRITE); the grant is then held for HOLD
// guard cycles with EN low (GUARD) before returning to IDLE. All outputs are registered.
// Ports:
//   CLK  rising-edge clock, shared with the flip-flop bank
//   RST  synchronous reset, active-high
//   bus  enff_write_arbiter_if.slave (REQ, DIN in; GNT, D, EN, BUSY out)
// Build option:
//   ENFF_ARB_FIXED_PRIO_EN  defined: fixed priority, requester 0 highest, no rotation pointer.
//                           undefined (default): round-robin starting at the pointer.
module enff_write_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 2
) (
  input logic              CLK,
  input logic              RST,
  enff_write_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam logic [3:0] GUARD_LOAD = (HOLD > 0) ? 4'(HOLD - 1) : 4'd0;

  generate
    if (NREQ < 2 || WIDTH < 1 || HOLD < 0 || HOLD > 15) begin : g_param_check
      $error("enff_write_arbiter: illegal parameters (NREQ>=2, WIDTH>=1, HOLD in 0..15)");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WRITE, GUARD} state_t;

  state_t           state_reg, state_next;
  logic [NREQ-1:0]  gnt_reg, gnt_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic             en_reg, en_next;
  logic             busy_reg, busy_next;
  logic [3:0]       cnt_reg, cnt_next;

  logic [NREQ-1:0]  req_pick;
  logic [IW-1:0]    win_idx;
  logic [WIDTH-1:0] din_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_din
      assign din_arr[gi] = bus.DIN[gi*WIDTH +: WIDTH];
    end
  endgenerate

`ifndef ENFF_ARB_FIXED_PRIO_EN
  logic [IW-1:0]   ptr_reg, ptr_next;
  logic [IW-1:0]   win_reg, win_next;
  logic [NREQ-1:0] req_masked;

  // Requests at or above the pointer take precedence; if none, wrap to the full vector.
  // A lowest-index search over this choice equals a circular search starting at the pointer.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
      assign req_masked[gi] = bus.REQ[gi] & (IW'(gi) >= ptr_reg);
    end
  endgenerate
  assign req_pick = (req_masked != '0) ? req_masked : bus.REQ;
`else
  assign req_pick = bus.REQ;
`endif

  // Lowest-index set bit of req_pick.
  always_comb begin
    win_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_pick[i]) win_idx = IW'(i);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      d_reg     <= '0;
      en_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
`ifndef ENFF_ARB_FIXED_PRIO_EN
      ptr_reg   <= '0;
      win_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      d_reg     <= d_next;
      en_reg    <= en_next;
      busy_reg  <= busy_next;
      cnt_reg   <= cnt_next;
`ifndef ENFF_ARB_FIXED_PRIO_EN
      ptr_reg   <= ptr_next;
      win_reg   <= win_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    d_next     = d_reg;
    en_next    = 1'b0;
    busy_next  = busy_reg;
    cnt_next   = cnt_reg;
`ifndef ENFF_ARB_FIXED_PRIO_EN
    ptr_next   = ptr_reg;
    win_next   = win_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.REQ != '0) begin
          gnt_next   = NREQ'(1) << win_idx;
          d_next     = din_arr[win_idx];
          en_next    = 1'b1;
          busy_next  = 1'b1;
          state_next = WRITE;
`ifndef ENFF_ARB_FIXED_PRIO_EN
          win_next   = win_idx;
`endif
        end
      end
      WRITE: begin
`ifndef ENFF_ARB_FIXED_PRIO_EN
        ptr_next = (win_reg == IW'(NREQ - 1)) ? '0 : win_reg + IW'(1);
`endif
        if (HOLD == 0) begin
          gnt_next   = '0;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          cnt_next   = GUARD_LOAD;
          state_next = GUARD;
        end
      end
      GUARD: begin
        if (cnt_reg == 4'd0) begin
          gnt_next   = '0;
          busy_next  = 1'b0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: begin
        gnt_next   = '0;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign bus.GNT  = gnt_reg;
  assign bus.D    = d_reg;
  assign bus.EN   = en_reg;
  assign bus.BUSY = busy_reg;
endmodule

// File: tb/tb_enff_write_arbiter.sv
// Testbench for enff_write_arbiter: three instances (HOLD = 0, 2, 5) share the same stimulus.
// A transaction-level model predicts every instance's outputs each cycle; a directed vector
// table and hand-written sequences cover the reset, guard, rotation and data-capture cases.
module tb_enff_write_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam logic [31:0] DB  = {8'h44, 8'hA5, 8'h3C, 8'h11};
  localparam logic [31:0] DBF = {8'h44, 8'hA5, 8'hFF, 8'h11};

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  enff_write_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) if0 ();
  enff_write_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) if2 ();
  enff_write_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) if5 ();

  assign if0.REQ = req;  assign if0.DIN = din;
  assign if2.REQ = req;  assign if2.DIN = din;
  assign if5.REQ = req;  assign if5.DIN = din;

  enff_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(0)) u0 (.CLK(clk), .RST(rst), .bus(if0));
  enff_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(2)) u2 (.CLK(clk), .RST(rst), .bus(if2));
  enff_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(5)) u5 (.CLK(clk), .RST(rst), .bus(if5));

  // {GNT, EN, BUSY, D} per instance
  logic [13:0] act [3];
  assign act[0] = {if0.GNT, if0.EN, if0.BUSY, if0.D};
  assign act[1] = {if2.GNT, if2.EN, if2.BUSY, if2.D};
  assign act[2] = {if5.GNT, if5.EN, if5.BUSY, if5.D};

  // Transaction model: a grant keeps the instance busy for HOLD+1 cycles, EN only in the first.
  int         m_hold [3] = '{0, 2, 5};
  int         m_rem  [3];
  int         m_win  [3];
  int         m_ptr  [3];
  logic [7:0] m_d    [3];

  function automatic int pick(input logic [3:0] r, input int p);
    int start;
`ifdef ENFF_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = p;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (r[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_update();
    int w;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_rem[k] = 0; m_ptr[k] = 0; m_win[k] = 0; m_d[k] = 8'h00;
      end else if (m_rem[k] > 0) begin
        m_rem[k] = m_rem[k] - 1;
      end else if (req != 4'b0000) begin
        w = pick(req, m_ptr[k]);
        m_win[k] = w;
        m_d[k]   = din[w*8 +: 8];
        m_ptr[k] = (w + 1) % NREQ;
        m_rem[k] = m_hold[k] + 1;
        if (k == 1) $display("txn: req=%b -> requester %0d data=%h", req, w, m_d[k]);
      end
    end
  endtask

  task automatic chk(input string name, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got gnt=%b en=%b busy=%b d=%h, expected gnt=%b en=%b busy=%b d=%h",
               name, got[13:10], got[9], got[8], got[7:0], exp[13:10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic check_model();
    logic [13:0] e;
    for (int k = 0; k < 3; k++) begin
      e[13:10] = (m_rem[k] > 0) ? 4'(1 << m_win[k]) : 4'b0000;
      e[9]     = (m_rem[k] > 0) && (m_rem[k] == m_hold[k] + 1);
      e[8]     = (m_rem[k] > 0);
      e[7:0]   = m_d[k];
      chk($sformatf("model_hold%0d", m_hold[k]), act[k], e);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q, input logic [31:0] dd);
    rst = r; req = q; din = dd;
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic        en;
    logic        busy;
    logic [7:0]  d;
  } vec_t;

  vec_t tbl [19];

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_rem[k] = 0; m_win[k] = 0; m_ptr[k] = 0; m_d[k] = 8'h00;
    end
    rst = 1'b1; req = 4'b0000; din = DB;

    // Expected outputs of the HOLD=2 instance after each edge.
    tbl[0]  = '{1'b1, 4'b1111, DB,  4'b0000, 1'b0, 1'b0, 8'h00}; // reset with all requesting
    tbl[1]  = '{1'b1, 4'b1111, DB,  4'b0000, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 4'b0100, DB,  4'b0100, 1'b1, 1'b1, 8'hA5}; // single requester 2
    tbl[3]  = '{1'b0, 4'b0000, DB,  4'b0100, 1'b0, 1'b1, 8'hA5};
    tbl[4]  = '{1'b0, 4'b0000, DB,  4'b0100, 1'b0, 1'b1, 8'hA5};
    tbl[5]  = '{1'b0, 4'b0000, DB,  4'b0000, 1'b0, 1'b0, 8'hA5};
    tbl[6]  = '{1'b0, 4'b0010, DB,  4'b0010, 1'b1, 1'b1, 8'h3C}; // requester 1, data 3C
    tbl[7]  = '{1'b0, 4'b0010, DBF, 4'b0010, 1'b0, 1'b1, 8'h3C}; // DIN changes mid-transaction
    tbl[8]  = '{1'b0, 4'b0010, DBF, 4'b0010, 1'b0, 1'b1, 8'h3C};
    tbl[9]  = '{1'b0, 4'b0000, DB,  4'b0000, 1'b0, 1'b0, 8'h3C};
    tbl[10] = '{1'b0, 4'b1000, DB,  4'b1000, 1'b1, 1'b1, 8'h44}; // grant 3 -> pointer wraps to 0
    tbl[11] = '{1'b0, 4'b0000, DB,  4'b1000, 1'b0, 1'b1, 8'h44};
    tbl[12] = '{1'b0, 4'b0000, DB,  4'b1000, 1'b0, 1'b1, 8'h44};
    tbl[13] = '{1'b0, 4'b0000, DB,  4'b0000, 1'b0, 1'b0, 8'h44};
    tbl[14] = '{1'b0, 4'b1001, DB,  4'b0001, 1'b1, 1'b1, 8'h11}; // 0 wins after 3
    tbl[15] = '{1'b0, 4'b0000, DB,  4'b0001, 1'b0, 1'b1, 8'h11};
    tbl[16] = '{1'b0, 4'b0000, DB,  4'b0001, 1'b0, 1'b1, 8'h11};
    tbl[17] = '{1'b0, 4'b0000, DB,  4'b0000, 1'b0, 1'b0, 8'h11};
`ifdef ENFF_ARB_FIXED_PRIO_EN
    tbl[18] = '{1'b0, 4'b1001, DB,  4'b0001, 1'b1, 1'b1, 8'h11}; // 0 always wins
`else
    tbl[18] = '{1'b0, 4'b1001, DB,  4'b1000, 1'b1, 1'b1, 8'h44}; // rotation moves on to 3
`endif

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].din);
      $display("vec %0d: rst=%b req=%b -> gnt=%b en=%b busy=%b d=%h",
               i, tbl[i].rst, tbl[i].req, if2.GNT, if2.EN, if2.BUSY, if2.D);
      chk($sformatf("vec%0d", i), act[1], {tbl[i].gnt, tbl[i].en, tbl[i].busy, tbl[i].d});
    end

    // HOLD=0 with everyone requesting: rotation and EN every second cycle.
    step(1'b1, 4'b0000, DB);
    for (int t = 0; t < 8; t++) begin
      logic [3:0] eg;
`ifdef ENFF_ARB_FIXED_PRIO_EN
      eg = 4'b0001;
`else
      eg = 4'(1 << (t % 4));
`endif
      step(1'b0, 4'b1111, DB);
      $display("rotate %0d: gnt=%b en=%b", t, if0.GNT, if0.EN);
      chk($sformatf("rotate_grant%0d", t), {act[0][13:8], 8'h00}, {eg, 1'b1, 1'b1, 8'h00});
      step(1'b0, 4'b1111, DB);
      chk($sformatf("rotate_gap%0d", t), {act[0][13:8], 8'h00}, {4'b0000, 1'b0, 1'b0, 8'h00});
    end

    // HOLD=5: reset in the second guard cycle drops the transaction and clears the pointer.
    step(1'b1, 4'b0000, DB);
    step(1'b0, 4'b0100, DB);
    chk("guard_grant", act[2], {4'b0100, 1'b1, 1'b1, 8'hA5});
    step(1'b0, 4'b0000, DB);
    step(1'b0, 4'b0000, DB);
    chk("guard_2nd", act[2], {4'b0100, 1'b0, 1'b1, 8'hA5});
    step(1'b1, 4'b0000, DB);
    $display("guard reset: gnt=%b busy=%b", if5.GNT, if5.BUSY);
    chk("guard_reset", act[2], {4'b0000, 1'b0, 1'b0, 8'h00});
    step(1'b0, 4'b1010, DB); // pointer back at 0 -> requester 1 ahead of 3
    $display("post reset grant: gnt=%b d=%h", if5.GNT, if5.D);
    chk("post_reset_grant", act[2], {4'b0010, 1'b1, 1'b1, 8'h3C});

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      logic       r;
      logic [3:0] q;
      r = ($urandom_range(0, 49) == 0);
      q = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      step(r, q, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
